// File: rtl/clause_weight_accum.sv
// -----------------------------------------------------------------------------
// clause_weight_accum
//
// Accumulates signed per-class clause weights for a clause-based classifier.
// A flat weight store (CLASSES x CLAUSEN entries of WW bits) is loaded in
// BUSW-wide beats while the block is idle. An inference then streams clause
// beats; every accepted beat whose clause fires adds the weight column of that
// clause to all class sums (two-stage pipeline, saturating arithmetic). After
// the final beat the pipeline drains, the argmax class is registered and the
// result is held until it is acknowledged or a new inference starts.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   wr_valid/beat/data   weight beat write (IDLE or DONE only)
//   start                one-cycle pulse, begins an inference from IDLE/DONE
//   cl_valid/cl_ready    clause beat handshake (ready only in ACCUM)
//   cl_idx/fire/last     clause number, clause output, final beat marker
//   sums                 packed signed class sums, class k at [k*SUMW +: SUMW]
//   class_out            index of the largest sum, lowest index on ties
//   sums_valid/sums_ack  result valid / result consumed
//   wr_err               one-cycle pulse for a rejected weight write
//   idx_err              sticky flag for an out-of-range clause index
// -----------------------------------------------------------------------------
module clause_weight_accum #(
  parameter int CLAUSEN = 128,
  parameter int CLASSES = 10,
  parameter int WW      = 9,
  parameter int BUSW    = 256,
  parameter int SUMW    = 16,
  localparam int NBEATS = (CLASSES * CLAUSEN * WW + BUSW - 1) / BUSW,
  localparam int BW     = $clog2(NBEATS),
  localparam int CW     = $clog2(CLAUSEN),
  localparam int KW     = $clog2(CLASSES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  input  logic [BW-1:0]           wr_beat,
  input  logic [BUSW-1:0]         wr_data,
  input  logic                    start,
  input  logic                    cl_valid,
  output logic                    cl_ready,
  input  logic [CW-1:0]           cl_idx,
  input  logic                    cl_fire,
  input  logic                    cl_last,
  output logic [CLASSES*SUMW-1:0] sums,
  output logic [KW-1:0]           class_out,
  output logic                    sums_valid,
  input  logic                    sums_ack,
  output logic                    wr_err,
  output logic                    idx_err
);

  localparam int STW = CLASSES * CLAUSEN * WW;  // weight store width in bits
  localparam int AW  = $clog2(STW);             // bit address into the store

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  logic       drain_cnt;

  logic idle_or_done;
  logic start_go;
  logic wr_ok;
  logic accept;
  logic idx_ok;

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign start_go     = start && idle_or_done;
  assign wr_ok        = wr_valid && idle_or_done && (32'(wr_beat) < NBEATS);
  assign cl_ready     = (state == S_ACCUM);
  assign accept       = cl_valid && cl_ready;
  assign idx_ok       = (32'(cl_idx) < CLAUSEN);

  // ---------------------------------------------------------------------------
  // Weight store: one register segment per beat. The last segment is cut short
  // when the store size is not a whole number of beats.
  // ---------------------------------------------------------------------------
  wire [STW-1:0] wstore;

  for (genvar b = 0; b < NBEATS; b++) begin : g_beat
    localparam int LO = b * BUSW;
    localparam int N  = (LO + BUSW > STW) ? (STW - LO) : BUSW;

    logic [N-1:0] seg;

    // NOTE: the weight store is built from flops, not RAM, so it can and must
    // clear on reset; a RAM-style store would have to be zeroed by writes.
    always_ff @(posedge clk) begin
      if (rst) begin
        seg <= '0;
      end else if (wr_ok && (32'(wr_beat) == b)) begin
        seg <= wr_data[N-1:0];
      end
    end

    assign wstore[LO +: N] = seg;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: select the weight column of the accepted clause for every class.
  // An out-of-range index is steered to clause 0 so the select never leaves
  // the store; its contribution is zeroed by the gate below anyway.
  // ---------------------------------------------------------------------------
  logic [CW-1:0]         idx_safe;
  logic signed [WW-1:0]  col    [CLASSES];
  logic signed [WW-1:0]  s1_col [CLASSES];
  logic                  s1_en;

  assign idx_safe = idx_ok ? cl_idx : '0;
  assign s1_en    = accept && cl_fire && idx_ok;

  always_comb begin
    logic [AW-1:0] base;
    // NOTE: every variable written here gets a value on every path, starting
    // with this default, so no latch can be inferred.
    base = '0;
    for (int k = 0; k < CLASSES; k++) begin
      base   = AW'((k * CLAUSEN + 32'(idx_safe)) * WW);
      col[k] = wstore[base +: WW];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CLASSES; k++) s1_col[k] <= '0;
    end else begin
      for (int k = 0; k < CLASSES; k++) s1_col[k] <= s1_en ? col[k] : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturating accumulate. The sum is widened by one bit so overflow
  // shows up as disagreeing top bits, then clamped to the signed limits.
  // ---------------------------------------------------------------------------
  function automatic logic signed [SUMW-1:0] sat_add(
    input logic signed [SUMW-1:0] a,
    input logic signed [WW-1:0]   b
  );
    logic [SUMW:0] t;
    t = {a[SUMW-1], a} + {{(SUMW + 1 - WW){b[WW-1]}}, b};
    if (t[SUMW] != t[SUMW-1]) begin
      return t[SUMW] ? {1'b1, {(SUMW - 1){1'b0}}} : {1'b0, {(SUMW - 1){1'b1}}};
    end
    return t[SUMW-1:0];
  endfunction

  logic signed [SUMW-1:0] sum_r [CLASSES];

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      for (int k = 0; k < CLASSES; k++) sum_r[k] <= '0;
    end else begin
      for (int k = 0; k < CLASSES; k++) sum_r[k] <= sat_add(sum_r[k], s1_col[k]);
    end
  end

  for (genvar k = 0; k < CLASSES; k++) begin : g_sums
    assign sums[k*SUMW +: SUMW] = sum_r[k];
  end

  // Argmax: a strictly-greater compare keeps the lowest index on ties.
  logic [KW-1:0]          best_idx;
  logic signed [SUMW-1:0] best_val;

  always_comb begin
    best_idx = '0;
    best_val = sum_r[0];
    for (int k = 1; k < CLASSES; k++) begin
      if (sum_r[k] > best_val) begin
        best_idx = KW'(k);
        best_val = sum_r[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. DRAIN lasts two cycles: one for the last beat to cross stage
  // 1 and one for it to land in the sums, so argmax sees final values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (accept && cl_last) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt) state <= S_DONE;
          drain_cnt <= ~drain_cnt;
        end
        S_DONE: begin
          if (start)         state <= S_ACCUM;
          else if (sums_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sums_valid <= 1'b0;
      class_out  <= '0;
      wr_err     <= 1'b0;
      idx_err    <= 1'b0;
    end else begin
      wr_err <= wr_valid && !wr_ok;

      if (start_go) begin
        sums_valid <= 1'b0;
      end else if (state == S_DRAIN && drain_cnt) begin
        sums_valid <= 1'b1;
        class_out  <= best_idx;
      end else if (state == S_DONE && sums_ack) begin
        sums_valid <= 1'b0;
      end

      if (start_go) begin
        idx_err <= 1'b0;
      end else if (accept && !idx_ok) begin
        idx_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clause_weight_accum.sv
// -----------------------------------------------------------------------------
// tb_clause_weight_accum
//
// Drives two instances that share every input and differ only in SUMW (16 and
// 12), so one stimulus stream exercises both the wide and the saturating
// accumulator. CLAUSEN=100 is not a power of two, which makes out-of-range
// clause indices representable on cl_idx. Expected sums come from a plain
// integer model of the weight table and saturating addition.
// -----------------------------------------------------------------------------
module tb_clause_weight_accum;

  localparam int CLAUSEN = 100;
  localparam int CLASSES = 10;
  localparam int WW      = 9;
  localparam int BUSW    = 256;
  localparam int SUMA    = 16;
  localparam int SUMB    = 12;
  localparam int STW     = CLASSES * CLAUSEN * WW;
  localparam int NBEATS  = (STW + BUSW - 1) / BUSW;
  localparam int PADW    = NBEATS * BUSW;
  localparam int BW      = $clog2(NBEATS);
  localparam int CW      = $clog2(CLAUSEN);
  localparam int KW      = $clog2(CLASSES);

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [BW-1:0]     wr_beat;
  logic [BUSW-1:0]   wr_data;
  logic              start;
  logic              cl_valid;
  logic [CW-1:0]     cl_idx;
  logic              cl_fire;
  logic              cl_last;
  logic              sums_ack;

  logic                    cl_ready_a, sums_valid_a, wr_err_a, idx_err_a;
  logic [CLASSES*SUMA-1:0] sums_a;
  logic [KW-1:0]           class_a;
  logic                    cl_ready_b, sums_valid_b, wr_err_b, idx_err_b;
  logic [CLASSES*SUMB-1:0] sums_b;
  logic [KW-1:0]           class_b;

  clause_weight_accum #(
    .CLAUSEN(CLAUSEN), .CLASSES(CLASSES), .WW(WW), .BUSW(BUSW), .SUMW(SUMA)
  ) dut_a (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_beat(wr_beat), .wr_data(wr_data),
    .start(start),
    .cl_valid(cl_valid), .cl_ready(cl_ready_a), .cl_idx(cl_idx),
    .cl_fire(cl_fire), .cl_last(cl_last),
    .sums(sums_a), .class_out(class_a), .sums_valid(sums_valid_a),
    .sums_ack(sums_ack), .wr_err(wr_err_a), .idx_err(idx_err_a)
  );

  clause_weight_accum #(
    .CLAUSEN(CLAUSEN), .CLASSES(CLASSES), .WW(WW), .BUSW(BUSW), .SUMW(SUMB)
  ) dut_b (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_beat(wr_beat), .wr_data(wr_data),
    .start(start),
    .cl_valid(cl_valid), .cl_ready(cl_ready_b), .cl_idx(cl_idx),
    .cl_fire(cl_fire), .cl_last(cl_last),
    .sums(sums_b), .class_out(class_b), .sums_valid(sums_valid_b),
    .sums_ack(sums_ack), .wr_err(wr_err_b), .idx_err(idx_err_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int w_m  [CLASSES][CLAUSEN];
  int sa_m [CLASSES];
  int sb_m [CLASSES];
  bit err_m;

  function automatic int sat_m(input int s, input int w, input int sw);
    int hi, lo, r;
    hi = (1 << (sw - 1)) - 1;
    lo = -(1 << (sw - 1));
    r  = s + w;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

  function automatic int argmax_m(input int s[CLASSES]);
    int b = 0;
    for (int k = 1; k < CLASSES; k++) if (s[k] > s[b]) b = k;
    return b;
  endfunction

  function automatic int sum_a(input int k);
    return int'($signed(sums_a[k*SUMA +: SUMA]));
  endfunction

  function automatic int sum_b(input int k);
    return int'($signed(sums_b[k*SUMB +: SUMB]));
  endfunction

  task automatic clear_model();
    for (int k = 0; k < CLASSES; k++) begin
      sa_m[k] = 0;
      sb_m[k] = 0;
    end
    err_m = 1'b0;
  endtask

  task automatic zero_weights();
    for (int k = 0; k < CLASSES; k++)
      for (int c = 0; c < CLAUSEN; c++) w_m[k][c] = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change and outputs are sampled 1ns after posedge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sums(input string tag);
    for (int k = 0; k < CLASSES; k++) begin
      check($sformatf("%s_sum16_%0d", tag, k), sum_a(k), sa_m[k]);
      check($sformatf("%s_sum12_%0d", tag, k), sum_b(k), sb_m[k]);
    end
    check({tag, "_idx_err16"}, int'(idx_err_a), int'(err_m));
    check({tag, "_idx_err12"}, int'(idx_err_b), int'(err_m));
  endtask

  task automatic check_results(input string tag);
    check_sums(tag);
    check({tag, "_class16"}, int'(class_a), argmax_m(sa_m));
    check({tag, "_class12"}, int'(class_b), argmax_m(sb_m));
  endtask

  // Writes every beat from the model table, highest beat first; beat 0 can
  // share its cycle with start.
  task automatic load_weights(input bit with_start);
    logic [PADW-1:0] pad;
    pad = '0;
    for (int i = STW; i < PADW; i++) pad[i] = 1'($urandom);
    for (int k = 0; k < CLASSES; k++)
      for (int c = 0; c < CLAUSEN; c++)
        pad[(k*CLAUSEN + c)*WW +: WW] = w_m[k][c][WW-1:0];
    for (int b = NBEATS - 1; b >= 0; b--) begin
      wr_valid = 1'b1;
      wr_beat  = BW'(b);
      wr_data  = pad[b*BUSW +: BUSW];
      start    = with_start && (b == 0);
      tick();
    end
    wr_valid = 1'b0;
    start    = 1'b0;
    if (with_start) clear_model();
  endtask

  task automatic begin_inf();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_model();
  endtask

  task automatic drive_beat(input int idx, input bit fire, input bit last);
    cl_valid = 1'b1;
    cl_idx   = CW'(idx);
    cl_fire  = fire;
    cl_last  = last;
    if (idx < CLAUSEN) begin
      if (fire) begin
        for (int k = 0; k < CLASSES; k++) begin
          sa_m[k] = sat_m(sa_m[k], w_m[k][idx], SUMA);
          sb_m[k] = sat_m(sb_m[k], w_m[k][idx], SUMB);
        end
      end
    end else begin
      err_m = 1'b1;
    end
    tick();
    cl_valid = 1'b0;
    cl_fire  = 1'b0;
    cl_last  = 1'b0;
  endtask

  // Called one cycle after the last beat; sums_valid must rise 3 cycles after
  // that beat, optionally with an ignored start pulse in the first DRAIN cycle.
  task automatic wait_done(input string tag, input bit drain_start);
    int lat = 1;
    if (drain_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      lat++;
    end
    while (!sums_valid_a && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_valid12"}, int'(sums_valid_b), 1);
  endtask

  task automatic ack();
    sums_ack = 1'b1;
    tick();
    sums_ack = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_beat = '0; wr_data = '0; start = 1'b0;
    cl_valid = 1'b0; cl_idx = '0; cl_fire = 1'b0; cl_last = 1'b0;
    sums_ack = 1'b0;
    zero_weights();
    clear_model();
    repeat (3) tick();

    // Reset state
    check("rst_cl_ready", int'(cl_ready_a), 0);
    check("rst_sums_valid", int'(sums_valid_a), 0);
    check("rst_class_out", int'(class_a), 0);
    check("rst_wr_err", int'(wr_err_a), 0);
    check_sums("rst");
    rst = 1'b0;
    tick();

    // weight(k,c) = k+1, five back-to-back fire beats on clauses 0..4
    for (int k = 0; k < CLASSES; k++)
      for (int c = 0; c < CLAUSEN; c++) w_m[k][c] = k + 1;
    load_weights(1'b0);
    check("load_wr_err", int'(wr_err_a), 0);
    begin_inf();
    check("accum_cl_ready", int'(cl_ready_a), 1);
    for (int i = 0; i < 5; i++) drive_beat(i, 1'b1, i == 4);
    wait_done("basic", 1'b1);
    check_results("basic");
    check("basic_sum9", sum_a(9), 50);
    check("basic_class", int'(class_a), 9);
    repeat (3) tick();
    check("done_hold_valid", int'(sums_valid_a), 1);
    check("done_hold_sum0", sum_a(0), 5);
    ack();
    check("ack_valid", int'(sums_valid_a), 0);
    check("ack_cl_ready", int'(cl_ready_a), 0);

    // Rejected write in ACCUM, two-cycle sum latency, out-of-range index
    begin_inf();
    wr_valid = 1'b1;
    wr_beat  = '0;
    wr_data  = {8{$urandom}};
    drive_beat(0, 1'b1, 1'b0);
    wr_valid = 1'b0;
    check("accum_wr_err", int'(wr_err_a), 1);
    check("sum_at_t1", sum_a(0), 0);
    tick();
    check("accum_wr_err_pulse", int'(wr_err_a), 0);
    check("sum_at_t2", sum_a(0), sa_m[0]);
    drive_beat(CLAUSEN, 1'b1, 1'b0);
    check("idx_err_set", int'(idx_err_a), 1);
    drive_beat(1, 1'b1, 1'b1);
    wait_done("wrerr", 1'b0);
    check_results("wrerr");
    ack();

    // Reset in the first DRAIN cycle aborts the inference
    begin_inf();
    for (int i = 0; i < 3; i++) drive_beat(i, 1'b1, i == 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    zero_weights();
    clear_model();
    check("drain_rst_ready", int'(cl_ready_a), 0);
    check("drain_rst_valid", int'(sums_valid_a), 0);
    check_sums("drain_rst");
    repeat (5) tick();
    check("drain_rst_later_valid", int'(sums_valid_a), 0);
    check_sums("drain_rst_later");

    // Saturation: weight(2,7)=+255, 200 fire beats on clause 7. 51000 is
    // beyond the signed 16-bit range, so both widths clamp at their maximum.
    zero_weights();
    w_m[2][7] = 255;
    load_weights(1'b0);
    begin_inf();
    for (int i = 0; i < 200; i++) drive_beat(7, 1'b1, i == 199);
    wait_done("sat", 1'b0);
    check_results("sat");
    check("sat_sum2_16", sum_a(2), 32767);
    check("sat_sum2_12", sum_b(2), 2047);
    ack();

    // Tie-break: two equal maxima, lowest index wins
    for (int k = 0; k < CLASSES; k++)
      for (int c = 0; c < CLAUSEN; c++) w_m[k][c] = -8;
    w_m[3][0] = -4;
    w_m[5][0] = -4;
    load_weights(1'b0);
    begin_inf();
    drive_beat(0, 1'b1, 1'b1);
    wait_done("tie", 1'b0);
    check_results("tie");
    check("tie_class", int'(class_a), 3);
    ack();

    // Write beat 0 in the same cycle as start: new weights apply
    for (int k = 0; k < CLASSES; k++)
      for (int c = 0; c < CLAUSEN; c++) w_m[k][c] = int'($urandom_range(0, 511)) - 256;
    load_weights(1'b1);
    for (int i = 0; i < 5; i++) drive_beat(int'($urandom_range(0, 27)), 1'b1, i == 4);
    wait_done("wr_start", 1'b0);
    check_results("wr_start");

    // start and sums_ack together in DONE: start wins
    start    = 1'b1;
    sums_ack = 1'b1;
    tick();
    start    = 1'b0;
    sums_ack = 1'b0;
    clear_model();
    check("restart_cl_ready", int'(cl_ready_a), 1);
    check("restart_valid", int'(sums_valid_a), 0);
    check_sums("restart");
    for (int i = 0; i < 3; i++) drive_beat(int'($urandom_range(0, CLAUSEN - 1)), 1'b1, i == 2);
    wait_done("restart", 1'b0);
    check_results("restart");
    ack();

    // Beat index beyond the store is rejected even in IDLE
    wr_valid = 1'b1;
    wr_beat  = BW'(NBEATS + 4);
    wr_data  = {8{$urandom}};
    tick();
    wr_valid = 1'b0;
    check("oob_beat_wr_err", int'(wr_err_a), 1);
    tick();
    check("oob_beat_wr_err_pulse", int'(wr_err_a), 0);

    // Randomized inferences
    for (int it = 0; it < 10; it++) begin
      bit ws;
      int n;
      for (int k = 0; k < CLASSES; k++)
        for (int c = 0; c < CLAUSEN; c++) w_m[k][c] = int'($urandom_range(0, 511)) - 256;
      ws = 1'($urandom);
      load_weights(ws);
      if (!ws) begin_inf();
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) begin
        int idx;
        while ($urandom_range(0, 3) == 0) tick();
        idx = ($urandom_range(0, 99) < 88) ? int'($urandom_range(0, CLAUSEN - 1))
                                           : int'($urandom_range(CLAUSEN, 127));
        start = ($urandom_range(0, 9) == 0);
        drive_beat(idx, $urandom_range(0, 9) < 7, i == n - 1);
        start = 1'b0;
      end
      wait_done($sformatf("rand%0d", it), 1'($urandom));
      check_results($sformatf("rand%0d", it));
      if ($urandom_range(0, 1) == 1) ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
